// File: rtl/median_frame_ctrl_if.sv
// rtl/median_frame_ctrl_if.sv - frame sequencer control/handshake bundle for the 2x2 median filter
//
// Signals:
//   start_i, pix_valid_i         source -> controller
//   busy_o, done_o, err_o        controller status
//   wr_en_o, wr_addr_o           line-buffer port A (write)
//   rd_en_o, rd_addr_o           line-buffer port B (read)
//   shift_o, out_valid_o         window shift / median output valid
//   x_o, y_o                     raster position of the next expected pixel
// Modports: master = pixel source / test driver, slave = controller.
interface median_frame_ctrl_if #(
    parameter int IMAGE_LEN    = 1080,
    parameter int IMAGE_HEIGHT = 720
);
    localparam int ADDR_W = $clog2(IMAGE_LEN);
    localparam int Y_W    = $clog2(IMAGE_HEIGHT);

    logic              start_i;
    logic              pix_valid_i;
    logic              busy_o;
    logic              done_o;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic              shift_o;
    logic              out_valid_o;
    logic [ADDR_W-1:0] x_o;
    logic [Y_W-1:0]    y_o;
    logic              err_o;

    modport master (
        output start_i, pix_valid_i,
        input  busy_o, done_o, wr_en_o, wr_addr_o, rd_en_o, rd_addr_o,
        input  shift_o, out_valid_o, x_o, y_o, err_o
    );

    modport slave (
        input  start_i, pix_valid_i,
        output busy_o, done_o, wr_en_o, wr_addr_o, rd_en_o, rd_addr_o,
        output shift_o, out_valid_o, x_o, y_o, err_o
    );
endinterface

// File: rtl/median_frame_ctrl.sv
// rtl/median_frame_ctrl.sv - frame sequencer for the 2x2 median filter datapath
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   median_frame_ctrl_if.slave: start/pixel-valid in; busy/done/err status,
//         line-buffer write/read enables and addresses, window shift, output valid,
//         raster x/y out.
// Optional feature: define MEDIAN_CTRL_ERR_EN to build sticky protocol-error
// detection on err_o; otherwise err_o is tied low.
//
// The line buffer is expected to be read-first on same-address collisions, so
// the read at column x returns the previous line one cycle later, in step with
// shift_o.
module median_frame_ctrl #(
    parameter int IMAGE_LEN    = 1080,
    parameter int IMAGE_HEIGHT = 720
) (
    input  logic                 clk,
    input  logic                 rst,
    median_frame_ctrl_if.slave   bus
);
    localparam int ADDR_W = $clog2(IMAGE_LEN);
    localparam int Y_W    = $clog2(IMAGE_HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW0,
        S_ROWS,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] x_q, xd_q;
    logic [Y_W-1:0]    y_q, yd_q;
    logic              drain_q;
    logic              shift_q;
    logic              out_valid_q;
    logic              accept;
    logic              x_last;
    logic              y_last;
    logic              busy;

    always_comb begin
        accept = bus.pix_valid_i && (state_q == S_ROW0 || state_q == S_ROWS);
        x_last = (x_q == ADDR_W'(IMAGE_LEN - 1));
        y_last = (y_q == Y_W'(IMAGE_HEIGHT - 1));
        busy   = (state_q == S_ROW0) || (state_q == S_ROWS) || (state_q == S_DRAIN);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start_i) state_d = S_ROW0;
            S_ROW0:  if (accept && x_last) state_d = S_ROWS;
            S_ROWS:  if (accept && x_last && y_last) state_d = S_DRAIN;
            // Two drain cycles let the last accept reach out_valid before DONE.
            S_DRAIN: if (drain_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            xd_q        <= '0;
            yd_q        <= '0;
            drain_q     <= 1'b0;
            shift_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= (state_q == S_DRAIN) && !drain_q;
            shift_q     <= accept;
            // Row 0 and column 0 have no complete 2x2 window.
            out_valid_q <= shift_q && (xd_q != '0) && (yd_q != '0);
            if (state_q == S_IDLE && bus.start_i) begin
                x_q <= '0;
                y_q <= '0;
            end else if (accept) begin
                xd_q <= x_q;
                yd_q <= y_q;
                if (x_last) begin
                    x_q <= '0;
                    // y holds on the final pixel; the frame ends instead of wrapping.
                    if (!y_last) y_q <= y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
        end
    end

`ifdef MEDIAN_CTRL_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((bus.pix_valid_i && !(state_q == S_ROW0 || state_q == S_ROWS)) ||
                     (bus.start_i && busy)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

    assign bus.busy_o      = busy;
    assign bus.done_o      = (state_q == S_DONE);
    assign bus.wr_en_o     = accept;
    assign bus.wr_addr_o   = x_q;
    assign bus.rd_en_o     = accept;
    assign bus.rd_addr_o   = x_q;
    assign bus.shift_o     = shift_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.x_o         = x_q;
    assign bus.y_o         = y_q;
endmodule

// File: tb/tb_median_frame_ctrl.sv
// tb/tb_median_frame_ctrl.sv - directed self-checking bench for median_frame_ctrl
module tb_median_frame_ctrl;
    localparam int LEN = 4;
    localparam int HGT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    median_frame_ctrl_if #(.IMAGE_LEN(LEN), .IMAGE_HEIGHT(HGT)) bus ();
    median_frame_ctrl #(.IMAGE_LEN(LEN), .IMAGE_HEIGHT(HGT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    median_frame_ctrl_if #(.IMAGE_LEN(2), .IMAGE_HEIGHT(2)) bus2 ();
    median_frame_ctrl #(.IMAGE_LEN(2), .IMAGE_HEIGHT(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc[$];
    int ov_cyc[$];
    int addr_q[$];
    int done_n;
    int done_cyc;
    int rw_bad;
    int xy_bad;
    int busy_after;
    int ov2_n = 0;
    int done2_n = 0;
    int wr2_n = 0;
    int exp_err;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock: drive inputs just after the edge, sample outputs on the falling edge.
    task automatic drive(input bit pv, input bit st, input bit r,
                         input bit pv2 = 1'b0, input bit st2 = 1'b0);
        bus.pix_valid_i  = pv;
        bus.start_i      = st;
        bus2.pix_valid_i = pv2;
        bus2.start_i     = st2;
        rst              = r;
        @(negedge clk);
        if (bus.wr_en_o) begin
            acc_cyc.push_back(cyc);
            addr_q.push_back(int'(bus.wr_addr_o));
        end
        if (bus.rd_en_o !== bus.wr_en_o ||
            (bus.wr_en_o && bus.rd_addr_o !== bus.wr_addr_o)) rw_bad++;
        if (bus.out_valid_o) ov_cyc.push_back(cyc);
        if (bus.done_o) begin
            done_n++;
            done_cyc = cyc;
        end
        if (bus2.out_valid_o) ov2_n++;
        if (bus2.done_o) done2_n++;
        if (bus2.wr_en_o) wr2_n++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_mon();
        acc_cyc.delete();
        ov_cyc.delete();
        addr_q.delete();
        done_n   = 0;
        done_cyc = -1;
        rw_bad   = 0;
        xy_bad   = 0;
    endtask

    // Start a frame and deliver n accepts; gaps=1 gives a 1010 valid pattern.
    // start_at (1-based accept index, 0 = never) also raises start_i on that accept.
    task automatic feed(input int n, input bit gaps, input int start_at);
        int  k;
        bit  ph;
        bit  pv;
        clear_mon();
        drive(1'b0, 1'b1, 1'b0);
        k  = 0;
        ph = 1'b0;
        for (int guard = 0; guard < 100 && k < n; guard++) begin
            pv = gaps ? ~ph : 1'b1;
            ph = ~ph;
            if (int'(bus.x_o) != k % LEN || int'(bus.y_o) != k / LEN) xy_bad++;
            drive(pv, pv && (k + 1 == start_at), 1'b0);
            if (pv) k++;
        end
    endtask

    task automatic finish_frame();
        for (int i = 0; i < 10 && done_n == 0; i++) drive(1'b0, 1'b0, 1'b0);
        busy_after = int'(bus.busy_o);
    endtask

    task automatic check_frame(input string t);
        int bad;
        int j;
        bad = 0;
        j   = 0;
        for (int k = 0; k < acc_cyc.size(); k++) begin
            if (k % LEN >= 1 && k / LEN >= 1) begin
                if (j >= ov_cyc.size() || ov_cyc[j] != acc_cyc[k] + 2) bad++;
                j++;
            end
        end
        chk({t, "_accepts"}, acc_cyc.size(), 12);
        chk({t, "_ov_count"}, ov_cyc.size(), 6);
        chk({t, "_ov_timing"}, bad, 0);
        chk({t, "_done_count"}, done_n, 1);
        chk({t, "_done_latency"},
            (done_n > 0 && acc_cyc.size() > 0) ? done_cyc - acc_cyc[acc_cyc.size() - 1] : -1, 3);
        chk({t, "_busy_after_done"}, busy_after, 0);
    endtask

    task automatic check_idle(input string t);
        chk({t, "_flags"}, int'({bus.busy_o, bus.done_o, bus.wr_en_o, bus.rd_en_o,
                                 bus.shift_o, bus.out_valid_o, bus.err_o}), 0);
        chk({t, "_x"}, int'(bus.x_o), 0);
        chk({t, "_y"}, int'(bus.y_o), 0);
    endtask

    initial begin
        int addr_bad;
        bus.start_i      = 1'b0;
        bus.pix_valid_i  = 1'b0;
        bus2.start_i     = 1'b0;
        bus2.pix_valid_i = 1'b0;
`ifdef MEDIAN_CTRL_ERR_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check_idle("reset");

        // Back-to-back frame.
        feed(12, 1'b0, 0);
        finish_frame();
        check_frame("b2b");
        chk("b2b_err", int'(bus.err_o), 0);

        // Line-buffer addressing from the same frame.
        addr_bad = 0;
        for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != i % LEN) addr_bad++;
        chk("addr_len", addr_q.size(), 12);
        chk("addr_seq", addr_bad, 0);
        chk("rd_eq_wr", rw_bad, 0);

        // Gapped frame.
        feed(12, 1'b1, 0);
        finish_frame();
        check_frame("gap");
        chk("gap_xy_step", xy_bad, 0);

        // start_i while busy.
        feed(12, 1'b0, 5);
        finish_frame();
        check_frame("midstart");
        chk("midstart_err", int'(bus.err_o), exp_err);

        // Abort with rst after accept 7: the accept-6 output lands, accept-7's is dropped.
        feed(7, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b1);
        check_idle("abort");
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b0);
        chk("abort_done", done_n, 0);
        chk("abort_ov", ov_cyc.size(), 1);
        feed(12, 1'b0, 0);
        finish_frame();
        check_frame("after_abort");

        // 2x2 image on the second instance.
        ov2_n   = 0;
        done2_n = 0;
        wr2_n   = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("small_ov", ov2_n, 1);
        chk("small_done", done2_n, 1);
        chk("small_wr", wr2_n, 4);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("small_idle_wr", wr2_n, 4);
        chk("small_idle_busy", int'(bus2.busy_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
